// File: rtl/time_bcd_counter.sv
// time_bcd_counter
// MM:SS stopwatch/clock core with BCD digit registers, a toggling pause
// state driven by a debounced button, and an adjust mode that bumps the
// selected field at the adjust tick rate. Minutes wrap at MIN_LIMIT.

module time_bcd_counter #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    output logic [3:0] sec_1s_out,
    output logic [3:0] sec_10s_out,
    output logic [3:0] min_1s_out,
    output logic [3:0] min_10s_out,
    output logic       paused,
    output logic       rollover
);

    // The minutes limit split into BCD digits so it can be compared directly
    // against the digit registers without any binary conversion.
    localparam logic [3:0] MIN_LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_LIM_ONES = 4'(MIN_LIMIT % 10);

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_PAUSED,
        MODE_ADJUST,
        MODE_CLEAR
    } mode_t;

    mode_t      mode;

    logic       pause_q;
    logic       pause_edge;

    logic       sec_at_max;
    logic       min_at_limit;

    logic [3:0] sec_inc_1s;
    logic [3:0] sec_inc_10s;
    logic [3:0] min_inc_1s;
    logic [3:0] min_inc_10s;

    logic [3:0] sec_1s_nxt;
    logic [3:0] sec_10s_nxt;
    logic [3:0] min_1s_nxt;
    logic [3:0] min_10s_nxt;
    logic       paused_nxt;
    logic       rollover_nxt;

    // Pause button sampler; cleared by reset so a level held through reset
    // release is treated as a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end

    // Operating mode: clear beats adjust, adjust beats the pause state.
    always_comb begin
        pause_edge = pause & ~pause_q;
        mode       = MODE_RUN;
        if (clr) begin
            mode = MODE_CLEAR;
        end else if (adj) begin
            mode = MODE_ADJUST;
        end else if (paused) begin
            mode = MODE_PAUSED;
        end
    end

    // Wrapping BCD increments for each field, computed in isolation; the
    // mode logic decides whether a seconds wrap carries into minutes.
    always_comb begin
        sec_at_max   = (sec_10s_out == 4'd5) && (sec_1s_out == 4'd9);
        min_at_limit = (min_10s_out == MIN_LIM_TENS) && (min_1s_out == MIN_LIM_ONES);

        sec_inc_1s  = sec_1s_out + 4'd1;
        sec_inc_10s = sec_10s_out;
        if (sec_1s_out == 4'd9) begin
            sec_inc_1s  = 4'd0;
            sec_inc_10s = sec_at_max ? 4'd0 : (sec_10s_out + 4'd1);
        end

        min_inc_1s  = min_1s_out + 4'd1;
        min_inc_10s = min_10s_out;
        if (min_at_limit) begin
            min_inc_1s  = 4'd0;
            min_inc_10s = 4'd0;
        end else if (min_1s_out == 4'd9) begin
            min_inc_1s  = 4'd0;
            min_inc_10s = min_10s_out + 4'd1;
        end
    end

    // Next-state decode: digits hold by default, pause toggles on any press
    // except during clear, rollover only fires on a counted full wrap.
    always_comb begin
        sec_1s_nxt   = sec_1s_out;
        sec_10s_nxt  = sec_10s_out;
        min_1s_nxt   = min_1s_out;
        min_10s_nxt  = min_10s_out;
        paused_nxt   = paused ^ pause_edge;
        rollover_nxt = 1'b0;

        case (mode)
            MODE_CLEAR: begin
                sec_1s_nxt  = 4'd0;
                sec_10s_nxt = 4'd0;
                min_1s_nxt  = 4'd0;
                min_10s_nxt = 4'd0;
                paused_nxt  = 1'b0;
            end
            MODE_ADJUST: begin
                if (tick_adj) begin
                    if (sel) begin
                        sec_1s_nxt  = sec_inc_1s;
                        sec_10s_nxt = sec_inc_10s;
                    end else begin
                        min_1s_nxt  = min_inc_1s;
                        min_10s_nxt = min_inc_10s;
                    end
                end
            end
            MODE_RUN: begin
                if (tick_1hz) begin
                    sec_1s_nxt  = sec_inc_1s;
                    sec_10s_nxt = sec_inc_10s;
                    if (sec_at_max) begin
                        min_1s_nxt   = min_inc_1s;
                        min_10s_nxt  = min_inc_10s;
                        rollover_nxt = min_at_limit;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output state registers; reset discards everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_1s_out  <= 4'd0;
            sec_10s_out <= 4'd0;
            min_1s_out  <= 4'd0;
            min_10s_out <= 4'd0;
            paused      <= 1'b0;
            rollover    <= 1'b0;
        end else begin
            sec_1s_out  <= sec_1s_nxt;
            sec_10s_out <= sec_10s_nxt;
            min_1s_out  <= min_1s_nxt;
            min_10s_out <= min_10s_nxt;
            paused      <= paused_nxt;
            rollover    <= rollover_nxt;
        end
    end

endmodule

// File: tb/tb_time_bcd_counter.sv
// tb_time_bcd_counter
// Drives directed scenarios and random traffic into time_bcd_counter and
// compares every cycle against a model that keeps time as plain integers.

module tb_time_bcd_counter;

    localparam int MIN_LIMIT = 59;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       pause;
    logic       adj;
    logic       sel;
    logic       tick_1hz;
    logic       tick_adj;
    logic [3:0] sec_1s_out;
    logic [3:0] sec_10s_out;
    logic [3:0] min_1s_out;
    logic [3:0] min_10s_out;
    logic       paused;
    logic       rollover;

    int n_checks   = 0;
    int n_pass     = 0;
    int roll_count = 0;
    bit compare_en = 0;

    // Model state: seconds and minutes as integers
    int m_sec        = 0;
    int m_min        = 0;
    bit m_paused     = 0;
    bit m_roll       = 0;
    bit m_pause_prev = 0;

    logic cur_pause = 1'b0;
    logic cur_adj   = 1'b0;
    logic cur_sel   = 1'b0;

    logic [15:0] dut_time;
    assign dut_time = {min_10s_out, min_1s_out, sec_10s_out, sec_1s_out};

    time_bcd_counter #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .pause      (pause),
        .adj        (adj),
        .sel        (sel),
        .tick_1hz   (tick_1hz),
        .tick_adj   (tick_adj),
        .sec_1s_out (sec_1s_out),
        .sec_10s_out(sec_10s_out),
        .min_1s_out (min_1s_out),
        .min_10s_out(min_10s_out),
        .paused     (paused),
        .rollover   (rollover)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_time();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic check_val(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, need %0h", name, $time, actual, expected);
        end
    endtask

    // Behavioural reference: one step of the stopwatch rules per clock edge
    always @(posedge clk or negedge rst) begin : model_step
        bit press;
        if (!rst) begin
            m_sec        = 0;
            m_min        = 0;
            m_paused     = 0;
            m_roll       = 0;
            m_pause_prev = 0;
        end else begin
            press        = pause && !m_pause_prev;
            m_pause_prev = pause;
            m_roll       = 0;
            if (clr) begin
                m_sec    = 0;
                m_min    = 0;
                m_paused = 0;
            end else begin
                if (adj) begin
                    if (tick_adj) begin
                        if (sel) m_sec = (m_sec + 1) % 60;
                        else     m_min = (m_min + 1) % (MIN_LIMIT + 1);
                    end
                end else if (!m_paused && tick_1hz) begin
                    m_sec = m_sec + 1;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min = m_min + 1;
                        if (m_min > MIN_LIMIT) begin
                            m_min  = 0;
                            m_roll = 1;
                        end
                    end
                end
                if (press) m_paused = !m_paused;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, just after the edge
    always @(posedge clk) begin
        #1;
        if (rollover) roll_count++;
        if (compare_en) begin
            check_val("cycle_time", int'(dut_time), int'(model_time()));
            check_val("cycle_paused", int'(paused), int'(m_paused));
            check_val("cycle_rollover", int'(rollover), int'(m_roll));
        end
    end

    task automatic apply_stimulus(input logic t1, input logic ta, input logic c);
        @(negedge clk);
        tick_1hz = t1;
        tick_adj = ta;
        clr      = c;
        pause    = cur_pause;
        adj      = cur_adj;
        sel      = cur_sel;
    endtask

    task automatic check_output(input string name, input logic [15:0] exp_time,
                                input logic exp_paused);
        check_val({name, "_time"}, int'(dut_time), int'(exp_time));
        check_val({name, "_paused"}, int'(paused), int'(exp_paused));
    endtask

    // Clear, then walk each field up to the wanted value in adjust mode
    task automatic preload(input int mm, input int ss);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        cur_adj = 1'b1;
        cur_sel = 1'b0;
        repeat (mm) apply_stimulus(1'b0, 1'b1, 1'b0);
        cur_sel = 1'b1;
        repeat (ss) apply_stimulus(1'b0, 1'b1, 1'b0);
        cur_adj = 1'b0;
        cur_sel = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin : main
        int r0;
        rst      = 1'b1;
        clr      = 1'b0;
        pause    = 1'b1;
        adj      = 1'b0;
        sel      = 1'b0;
        tick_1hz = 1'b0;
        tick_adj = 1'b0;
        cur_pause = 1'b1;
        #1 rst = 1'b0;
        #1 compare_en = 1'b1;
        #1;
        check_output("reset", 16'h0000, 1'b0);
        check_val("reset_rollover", int'(rollover), 0);

        // Pause held through reset release counts as exactly one press
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("held_pause", 16'h0000, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("held_pause_once", 16'h0000, 1'b1);
        cur_pause = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("clear_unpause", 16'h0000, 1'b0);

        // 75 seconds of counting
        roll_count = 0;
        repeat (75) apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("run75", 16'h0115, 1'b0);
        check_val("run75_no_rollover", roll_count, 0);

        // Both ticks in run mode give a single increment
        preload(0, 9);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("dual_tick", 16'h0010, 1'b0);

        // Full wrap with a one-cycle rollover pulse
        preload(59, 58);
        check_output("preload_5958", 16'h5958, 1'b0);
        r0 = roll_count;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("wrap_first", 16'h5959, 1'b0);
        check_val("wrap_first_rollover", int'(rollover), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("wrap_second", 16'h0000, 1'b0);
        check_val("wrap_rollover_high", int'(rollover), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_val("wrap_rollover_low", int'(rollover), 0);
        check_val("wrap_rollover_count", roll_count - r0, 1);

        // Pause, ignored ticks, resume, three counted ticks
        cur_pause = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("paused_on", 16'h0000, 1'b1);
        repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("paused_hold", 16'h0000, 1'b1);
        cur_pause = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        cur_pause = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("paused_off", 16'h0000, 1'b0);
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("resume3", 16'h0003, 1'b0);
        cur_pause = 1'b0;

        // Adjust seconds with interleaved 1 Hz ticks, then minutes
        preload(0, 58);
        cur_adj = 1'b1;
        cur_sel = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("adj_sec", 16'h0001, 1'b0);
        cur_sel = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("adj_min", 16'h0201, 1'b0);
        cur_adj = 1'b0;

        // Asynchronous reset mid-count, visible without a clock edge
        preload(12, 33);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("pre_reset", 16'h1234, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_output("async_reset", 16'h0000, 1'b0);
        check_val("async_reset_rollover", int'(rollover), 0);
        @(negedge clk);
        rst = 1'b1;

        // Clear wins over a simultaneous tick
        preload(5, 5);
        check_output("preload_0505", 16'h0505, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("clear_tick", 16'h0000, 1'b0);

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 16 == 0) cur_pause = ~cur_pause;
            if ($urandom % 32 == 0) cur_adj = ~cur_adj;
            if ($urandom % 8 == 0)  cur_sel = ~cur_sel;
            apply_stimulus(1'($urandom % 3 == 0), 1'($urandom % 4 == 0),
                           1'($urandom % 200 == 0));
            if ($urandom % 600 == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
